// File: rtl/gnn_result_serializer.sv
// Collects the eight out0/out1 node results of a GNN layer as their ready
// flags rise, then streams them as one frame over a valid/ready port in slot
// order (slot k = 2*node + out). A sticky overrun flag records any result
// that was overwritten before use or that arrived while a frame was draining.
module gnn_result_serializer #(
  parameter int DATA_W = 21
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] res0_node0,
  input  logic signed [DATA_W-1:0] res1_node0,
  input  logic signed [DATA_W-1:0] res0_node1,
  input  logic signed [DATA_W-1:0] res1_node1,
  input  logic signed [DATA_W-1:0] res0_node2,
  input  logic signed [DATA_W-1:0] res1_node2,
  input  logic signed [DATA_W-1:0] res0_node3,
  input  logic signed [DATA_W-1:0] res1_node3,
  input  logic                     rdy0_node0,
  input  logic                     rdy1_node0,
  input  logic                     rdy0_node1,
  input  logic                     rdy1_node1,
  input  logic                     rdy0_node2,
  input  logic                     rdy1_node2,
  input  logic                     rdy0_node3,
  input  logic                     rdy1_node3,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic signed [DATA_W-1:0] tx_data,
  output logic [2:0]               tx_idx,
  output logic                     tx_last,
  output logic                     frame_done,
  output logic [7:0]               frame_cnt,
  input  logic                     ovr_clr,
  output logic                     overrun
);

  typedef enum logic {COLLECT = 1'b0, SEND = 1'b1} state_t;

  state_t                     state_q, state_d;
  logic [7:0]                 rdy, prev_q, rise;
  logic [7:0]                 vld_q, vld_d;
  logic signed [DATA_W-1:0]   res    [8];
  logic signed [DATA_W-1:0]   slot_q [8];
  logic signed [DATA_W-1:0]   slot_d [8];
  logic [2:0]                 idx_q, idx_d;
  logic                       fd_q, fd_d;
  logic [7:0]                 cnt_q, cnt_d;
  logic                       ovr_q, ovr_d;
  logic                       ovr_evt;
  logic                       xfer;

  // Flatten the per-node ports into slot order k = 2*node + out.
  assign rdy = {rdy1_node3, rdy0_node3, rdy1_node2, rdy0_node2,
                rdy1_node1, rdy0_node1, rdy1_node0, rdy0_node0};
  assign res[0] = res0_node0;
  assign res[1] = res1_node0;
  assign res[2] = res0_node1;
  assign res[3] = res1_node1;
  assign res[4] = res0_node2;
  assign res[5] = res1_node2;
  assign res[6] = res0_node3;
  assign res[7] = res1_node3;

  // A ready flag already high when reset releases counts as a rise.
  assign rise = rdy & ~prev_q;
  assign xfer = (state_q == SEND) & tx_ready;

  // Next-state: capture in COLLECT, advance the read index in SEND.
  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    slot_d  = slot_q;
    idx_d   = idx_q;
    fd_d    = 1'b0;
    cnt_d   = cnt_q;
    ovr_evt = 1'b0;
    if (state_q == COLLECT) begin
      for (int k = 0; k < 8; k++) begin
        if (rise[k]) begin
          slot_d[k] = res[k];
          vld_d[k]  = 1'b1;
          if (vld_q[k]) ovr_evt = 1'b1;
        end
      end
      // Captures made on this edge count toward a complete frame.
      if (&vld_d) begin
        state_d = SEND;
        idx_d   = 3'd0;
      end
    end else begin
      // Slots are frozen while draining; any new result is lost.
      ovr_evt = |rise;
      if (xfer) begin
        if (idx_q == 3'd7) begin
          state_d = COLLECT;
          vld_d   = 8'd0;
          idx_d   = 3'd0;
          fd_d    = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
    end
    // A new overrun event beats a simultaneous clear.
    ovr_d = ovr_evt ? 1'b1 : (ovr_clr ? 1'b0 : ovr_q);
  end

  // State register; prev_q tracks the ready levels every cycle in both states.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      prev_q  <= 8'd0;
      vld_q   <= 8'd0;
      idx_q   <= 3'd0;
      fd_q    <= 1'b0;
      cnt_q   <= 8'd0;
      ovr_q   <= 1'b0;
      for (int k = 0; k < 8; k++) slot_q[k] <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= rdy;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
      fd_q    <= fd_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      for (int k = 0; k < 8; k++) slot_q[k] <= slot_d[k];
    end
  end

  // idx_q is held at 0 in COLLECT, so tx_data shows slot 0 there.
  assign tx_valid   = (state_q == SEND);
  assign tx_idx     = idx_q;
  assign tx_data    = slot_q[idx_q];
  assign tx_last    = tx_valid & (idx_q == 3'd7);
  assign frame_done = fd_q;
  assign frame_cnt  = cnt_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_gnn_result_serializer.sv
// Testbench for gnn_result_serializer: frame-level table, hand-written corner
// sequences and a randomized phase, all compared against a behavioural model.
module tb_gnn_result_serializer;

  localparam int DATA_W = 21;

  logic                     clk = 1'b0;
  logic                     rst;
  logic signed [DATA_W-1:0] res [8];
  logic [7:0]               rdy;
  logic                     tx_valid, tx_ready, tx_last, frame_done, ovr_clr, overrun;
  logic signed [DATA_W-1:0] tx_data;
  logic [2:0]               tx_idx;
  logic [7:0]               frame_cnt;

  int nerr = 0;
  int nchk = 0;

  // Behavioural model state: slot contents, which slots hold fresh data,
  // whether a frame is being drained and which word is on offer.
  int       m_slot [8];
  logic [7:0] m_prev, m_vld;
  bit       m_send, m_fd, m_ovr;
  int       m_idx, m_cnt;

  gnn_result_serializer #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .res0_node0(res[0]), .res1_node0(res[1]), .res0_node1(res[2]), .res1_node1(res[3]),
    .res0_node2(res[4]), .res1_node2(res[5]), .res0_node3(res[6]), .res1_node3(res[7]),
    .rdy0_node0(rdy[0]), .rdy1_node0(rdy[1]), .rdy0_node1(rdy[2]), .rdy1_node1(rdy[3]),
    .rdy0_node2(rdy[4]), .rdy1_node2(rdy[5]), .rdy0_node3(rdy[6]), .rdy1_node3(rdy[7]),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_idx(tx_idx),
    .tx_last(tx_last), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .ovr_clr(ovr_clr), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply the rules to the inputs present just before the edge.
  task automatic model_step();
    bit ev;
    int nfresh;
    logic [7:0] r;
    if (rst) begin
      m_send = 0; m_fd = 0; m_ovr = 0; m_idx = 0; m_cnt = 0;
      m_prev = 0; m_vld = 0;
      for (int k = 0; k < 8; k++) m_slot[k] = 0;
      return;
    end
    r = rdy & ~m_prev;
    ev = 0;
    m_fd = 0;
    if (!m_send) begin
      for (int k = 0; k < 8; k++)
        if (r[k]) begin
          if (m_vld[k]) ev = 1;
          m_slot[k] = int'(res[k]);
          m_vld[k] = 1'b1;
        end
      nfresh = 0;
      for (int k = 0; k < 8; k++) nfresh += int'(m_vld[k]);
      if (nfresh == 8) begin m_send = 1; m_idx = 0; end
    end else begin
      if (r != 0) ev = 1;
      if (tx_ready) begin
        if (m_idx == 7) begin
          m_send = 0; m_vld = 0; m_idx = 0; m_fd = 1;
          m_cnt = (m_cnt + 1) % 256;
        end else m_idx++;
      end
    end
    if (ev) m_ovr = 1;
    else if (ovr_clr) m_ovr = 0;
    m_prev = rdy;
  endtask

  task automatic check_cycle();
    chk("tx_valid", int'(tx_valid), int'(m_send));
    chk("tx_idx", int'(tx_idx), m_send ? m_idx : 0);
    chk("tx_data", int'(tx_data), m_send ? m_slot[m_idx] : m_slot[0]);
    chk("tx_last", int'(tx_last), int'(m_send && m_idx == 7));
    chk("frame_done", int'(frame_done), int'(m_fd));
    chk("frame_cnt", int'(frame_cnt), m_cnt);
    chk("overrun", int'(overrun), int'(m_ovr));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_cycle();
  endtask

  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  // All eight results arrive together; drain with optional 1/0 backpressure.
  task automatic run_frame(input int base, input int step, input bit bp, output int cycles);
    int n, got;
    bit done;
    for (int k = 0; k < 8; k++) res[k] = DATA_W'(base + step * k);
    rdy = 8'hFF; tx_ready = 0;
    tick();
    chk("frame_valid_next", int'(tx_valid), 1);
    n = 0; got = 0; done = 0;
    while (!done && n < 40) begin
      n++;
      tx_ready = bp ? n[0] : 1'b1;
      if (tx_valid && tx_ready) begin
        chk("word_data", int'(tx_data), base + step * got);
        chk("word_idx", int'(tx_idx), got);
        chk("word_last", int'(tx_last), int'(got == 7));
        got++;
        if (got == 8) done = 1;
      end
      tick();
    end
    if (!done) chk("frame_timeout", got, 8);
    cycles = n;
    chk("frame_done_pulse", int'(frame_done), 1);
    tx_ready = 0; rdy = 8'h00;
    tick();
    chk("frame_done_once", int'(frame_done), 0);
  endtask

  typedef struct {
    int base;
    int step;
    bit bp;
    int exp_cycles;
  } vec_t;

  initial begin
    vec_t tbl [5];
    int cyc;
    logic [31:0] rnd;

    tbl[0] = '{100, 1, 1'b0, 8};
    tbl[1] = '{-1048576, 1, 1'b0, 8};
    tbl[2] = '{1048575, -1, 1'b1, 15};
    tbl[3] = '{-5, -3, 1'b1, 15};
    tbl[4] = '{0, 0, 1'b0, 8};

    rst = 1; rdy = 0; tx_ready = 0; ovr_clr = 0;
    for (int k = 0; k < 8; k++) res[k] = '0;
    m_prev = 0; m_vld = 0; m_send = 0; m_fd = 0; m_ovr = 0; m_idx = 0; m_cnt = 0;
    for (int k = 0; k < 8; k++) m_slot[k] = 0;

    // Reset state
    do_reset();
    chk("rst_valid", int'(tx_valid), 0);
    chk("rst_data", int'(tx_data), 0);
    chk("rst_cnt", int'(frame_cnt), 0);

    // Table of whole frames
    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i].base, tbl[i].step, tbl[i].bp, cyc);
      chk("frame_cycles", cyc, tbl[i].exp_cycles);
      chk("frame_cnt_tbl", int'(frame_cnt), i + 1);
    end

    // Staggered arrival, slot 7 last, slot 0 at the negative extreme
    for (int s = 0; s < 8; s++) begin
      res[s] = (s == 0) ? DATA_W'(-1048576) : DATA_W'(s * 7);
      rdy[s] = 1'b1;
      tick();
      chk("stagger_valid", int'(tx_valid), int'(s == 7));
    end
    chk("stagger_word0", int'(tx_data), -1048576);
    tx_ready = 1;
    for (int i = 0; i < 8; i++) tick();
    tx_ready = 0; rdy = 0; tick();

    // Overrun while draining; held level not recaptured; set beats clear
    do_reset();
    for (int k = 0; k < 8; k++) res[k] = DATA_W'(500 + k);
    rdy = 8'hFF; tick();
    rdy[5] = 0; tick();
    rdy[5] = 1; tick();
    chk("ovr_in_send", int'(overrun), 1);
    tx_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("ovr_frame_word", int'(tx_data), 500 + i);
      tick();
    end
    tx_ready = 0;
    rdy = 8'h20; tick();
    rdy = 8'hFF; tick(); tick(); tick();
    chk("no_recapture", int'(tx_valid), 0);
    rdy[0] = 0; tick();
    rdy[0] = 1; ovr_clr = 1; tick(); ovr_clr = 0;
    chk("ovr_set_wins", int'(overrun), 1);
    ovr_clr = 1; tick(); ovr_clr = 0;
    chk("ovr_clear", int'(overrun), 0);
    rdy[5] = 0; tick();
    rdy[5] = 1; tick();
    chk("ovr_recollect", int'(tx_valid), 1);
    tx_ready = 1;
    for (int i = 0; i < 8; i++) tick();
    tx_ready = 0; rdy = 0; tick();

    // Reset in the middle of a frame
    do_reset();
    for (int k = 0; k < 8; k++) res[k] = DATA_W'(200 + k);
    rdy = 8'hFF; tick();
    tx_ready = 1;
    for (int i = 0; i < 3; i++) tick();
    rst = 1; tick();
    chk("mid_rst_valid", int'(tx_valid), 0);
    chk("mid_rst_idx", int'(tx_idx), 0);
    chk("mid_rst_data", int'(tx_data), 0);
    chk("mid_rst_fd", int'(frame_done), 0);
    chk("mid_rst_cnt", int'(frame_cnt), 0);
    rst = 0; tick();
    chk("mid_rst_fd_after", int'(frame_done), 0);
    chk("mid_rst_restart", int'(tx_valid), 1);
    chk("mid_rst_word0", int'(tx_data), 200);
    for (int i = 0; i < 8; i++) tick();
    tx_ready = 0; rdy = 0; tick();

    // frame_cnt wraps after 256 frames
    do_reset();
    for (int f = 0; f < 256; f++) begin
      run_frame(f, 3, 1'b0, cyc);
      if (f == 254) chk("wrap_255", int'(frame_cnt), 255);
    end
    chk("wrap_0", int'(frame_cnt), 0);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 5) == 0) begin
          rdy[k] = ~rdy[k];
          if (rdy[k]) begin
            rnd = $urandom;
            res[k] = rnd[DATA_W-1:0];
          end
        end
      end
      tx_ready = ($urandom_range(0, 2) != 0);
      ovr_clr  = ($urandom_range(0, 15) == 0);
      rst      = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 0; ovr_clr = 0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
